oled_text_sequencer: RTL and testbench
======================================

Name: oled_text_sequencer

Overview:
- Controller in front of OLED_interface: owns its i_MODE/i_START handshake and the flat i_ASCII character bus.
- Runs the power-on sequence after reset, then issues a text-render pass whenever the character buffer changes.
- Arbitrates character writes from two requesters (A, B) into a working buffer; snapshots it into a stable display buffer at the start of each render.

Parameters:
- NUM_COL, 96, OLED pixel columns
- NUM_ROW, 64, OLED pixel rows
- ASCII_COL_SIZE, 8, pixel width per character
- ASCII_ROW_SIZE, 8, pixel height per character
- NUM_CHARS, (NUM_COL/ASCII_COL_SIZE)*(NUM_ROW/ASCII_ROW_SIZE) = 96, character cells
- ADDR_W, 7, character-address width (must satisfy 2^ADDR_W >= NUM_CHARS)
- BUSY_TIMEOUT, 64, cycles allowed for i_READY to fall after o_START
- REFRESH_PERIOD, 5_000_000, idle cycles between forced refreshes (optional feature only)

Ports:
- i_CLK  in  1  system clock
- i_RST  in  1  synchronous, active-high reset
- i_A_VALID  in  1  requester A write request
- i_A_ADDR  in  ADDR_W  A cell index (0 = top-left, row-major)
- i_A_DATA  in  8  A ASCII code
- o_A_READY  out  1  A write accepted this cycle
- i_B_VALID, i_B_ADDR, i_B_DATA, o_B_READY: same for requester B
- i_READY  in  1  OLED_interface o_READY
- o_MODE  out  2  to OLED_interface i_MODE
- o_START  out  1  one-cycle start pulse
- o_ASCII  out  NUM_CHARS*8  display buffer; cell k at bits [(NUM_CHARS-1-k)*8 +: 8]
- o_BUSY  out  1  render or power-on in progress
- o_ERR  out  1  sticky: timeout or out-of-range address; cleared only by reset

Behaviour:
- Mode codes, fixed: 2'b00 power-on, 2'b10 text render.
- Reset values:
  - o_START=0, o_MODE=00, o_BUSY=1, o_ERR=0
  - o_ASCII and working buffer all 8'h20 (space)
  - dirty=1; round-robin pointer = A; state INIT_START
- States and transitions:
  - INIT_START: wait i_READY=1, then pulse o_START (MODE 00) -> INIT_BUSY.
  - INIT_BUSY: i_READY=0 -> INIT_DONE. BUSY_TIMEOUT expiry -> set o_ERR, go INIT_START (retry).
  - INIT_DONE: i_READY=1 -> IDLE.
  - IDLE: o_BUSY=0. dirty=1 and i_READY=1 -> SNAP.
  - SNAP: o_ASCII <= working buffer, dirty <= 0 -> REF_START.
  - REF_START: o_START=1 for exactly one cycle (MODE 10) -> REF_BUSY.
  - REF_BUSY: i_READY=0 -> REF_DONE. Timeout -> set o_ERR, go IDLE with dirty forced to 1.
  - REF_DONE: i_READY=1 -> IDLE.
- o_MODE is held stable from the cycle before o_START until return to IDLE.
- Writes:
  - Accepted in every state, including INIT and render.
  - At most one write per cycle; o_X_READY is combinational from VALID and the arbiter.
  - Both VALID: grant goes to the pointer side; pointer then flips to the other side.
  - Single VALID: granted immediately; pointer flips away from the granted side.
  - Accepted write with addr < NUM_CHARS: working[addr] <= data; dirty <= 1 on the next edge.
  - Accepted write with addr >= NUM_CHARS: data discarded, o_ERR set, dirty unchanged.
- Write in the same cycle as SNAP: snapshot takes the pre-write value; dirty stays 1, so a second refresh follows.
- o_ASCII changes only in SNAP, so it is stable for the whole render.
- Latency: write to o_START is at least 3 cycles (write, SNAP, REF_START) when IDLE with i_READY=1.
- Reset asserted mid-render: immediate return to reset values; o_START never glitches high.

Optional Feature:
- Macro OLED_SEQ_PERIODIC_REFRESH_EN.
- Defined: a counter runs in IDLE only and clears on leaving IDLE. At REFRESH_PERIOD-1 it sets dirty=1, forcing a re-render even with no writes.
- Undefined: no counter; renders occur only on writes or after a timeout.

Decomposition:
- Shared package oled_pkg: MODE_ON=2'b00, MODE_TEXT=2'b10, ASCII_SPACE=8'h20, state enum, NUM_CHARS derivation.
- One natural sub-module: oled_rr_arbiter (2-way round-robin; VALID in, grant/READY out, pointer state).

Test Plan:
- Reset, then i_READY drops 5 cycles after o_START and rises after 20 -> one o_START with MODE 00; IDLE; dirty render issued with MODE 10; o_ASCII all 8'h20.
- A writes addr 0 = 8'h45 ("E") in IDLE -> o_ASCII[767:760]=8'h45 after SNAP; o_START at write+3; o_BUSY high until REF_DONE exits.
- A and B VALID on 4 consecutive cycles (pointer=A) -> grants A,B,A,B; the later value wins per cell.
- B writes addr 96 -> o_B_READY=1, o_ERR=1, buffer unchanged, no render issued.
- Hold i_READY=1 after a MODE 10 o_START -> timeout after 64 cycles; o_ERR=1; a render retry is issued.
- With OLED_SEQ_PERIODIC_REFRESH_EN and REFRESH_PERIOD=100, no writes -> o_START every ~100+render cycles; without the macro -> no further o_START.

Source files
------------

// File: rtl/oled_pkg.sv
// Shared constants, mode codes and state encoding for the OLED text sequencer.
// Optional build macro used by the top: OLED_SEQ_PERIODIC_REFRESH_EN.
package oled_pkg;

  localparam int NUM_COL        = 96;
  localparam int NUM_ROW        = 64;
  localparam int ASCII_COL_SIZE = 8;
  localparam int ASCII_ROW_SIZE = 8;
  localparam int NUM_CHARS      = (NUM_COL / ASCII_COL_SIZE) * (NUM_ROW / ASCII_ROW_SIZE);
  localparam int ADDR_W         = 7;
  localparam int BUSY_TIMEOUT   = 64;
  localparam int REFRESH_PERIOD = 5_000_000;

  localparam logic [1:0] MODE_ON     = 2'b00;
  localparam logic [1:0] MODE_TEXT   = 2'b10;
  localparam logic [7:0] ASCII_SPACE = 8'h20;

  typedef enum logic [2:0] {
    ST_INIT_START,
    ST_INIT_BUSY,
    ST_INIT_DONE,
    ST_IDLE,
    ST_SNAP,
    ST_REF_START,
    ST_REF_BUSY,
    ST_REF_DONE
  } seq_state_t;

  // Bit offset of character cell k inside the flat display bus (cell 0 in the top byte).
  function automatic int cell_lsb(input int k);
    return (NUM_CHARS - 1 - k) * 8;
  endfunction

endpackage

// File: rtl/oled_text_sequencer_if.sv
// Bus bundle between the text sequencer, its two character writers and the OLED_interface.
//
// Handshake semantics: a requester raises i_X_VALID with i_X_ADDR/i_X_DATA stable; the write
// is taken on the rising clock edge of any cycle in which i_X_VALID and o_X_READY are both
// high. o_X_READY is combinational from the VALID lines and the arbiter pointer, so a
// requester that sees READY low keeps its request up and retries next cycle. On the OLED
// side o_START is a single-cycle pulse; i_READY low means the OLED_interface is working.
interface oled_text_sequencer_if;

  logic                        i_A_VALID;
  logic [oled_pkg::ADDR_W-1:0] i_A_ADDR;
  logic [7:0]                  i_A_DATA;
  logic                        o_A_READY;

  logic                        i_B_VALID;
  logic [oled_pkg::ADDR_W-1:0] i_B_ADDR;
  logic [7:0]                  i_B_DATA;
  logic                        o_B_READY;

  logic                             i_READY;
  logic [1:0]                       o_MODE;
  logic                             o_START;
  logic [oled_pkg::NUM_CHARS*8-1:0] o_ASCII;

  // Sequencer view.
  modport master (
    input  i_A_VALID, i_A_ADDR, i_A_DATA,
    input  i_B_VALID, i_B_ADDR, i_B_DATA,
    input  i_READY,
    output o_A_READY, o_B_READY,
    output o_MODE, o_START, o_ASCII
  );

  // Requester / OLED_interface view.
  modport slave (
    output i_A_VALID, i_A_ADDR, i_A_DATA,
    output i_B_VALID, i_B_ADDR, i_B_DATA,
    output i_READY,
    input  o_A_READY, o_B_READY,
    input  o_MODE, o_START, o_ASCII
  );

endinterface

// File: rtl/oled_rr_arbiter.sv
// Two-way round-robin arbiter: one grant per cycle, pointer flips away from the winner.
module oled_rr_arbiter (
  input  logic i_CLK,
  input  logic i_RST,
  input  logic a_valid,
  input  logic b_valid,
  output logic a_grant,
  output logic b_grant
);

  logic ptr_b;  // 0: A has priority, 1: B has priority

  // Grant: contention goes to the pointer side, a lone request wins outright.
  always_comb begin
    a_grant = 1'b0;
    b_grant = 1'b0;
    if (a_valid && b_valid) begin
      a_grant = !ptr_b;
      b_grant = ptr_b;
    end else begin
      a_grant = a_valid;
      b_grant = b_valid;
    end
  end

  // Pointer: hand priority to the side that did not win.
  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      ptr_b <= 1'b0;
    end else if (a_grant) begin
      ptr_b <= 1'b1;
    end else if (b_grant) begin
      ptr_b <= 1'b0;
    end
  end

endmodule

// File: rtl/oled_text_sequencer.sv
// OLED text sequencer: power-on sequence, buffered character writes from two requesters,
// and a text render whenever the buffer has changed.
// Build option: define OLED_SEQ_PERIODIC_REFRESH_EN to force a re-render after
// REFRESH_PERIOD idle cycles even without writes.
module oled_text_sequencer
  import oled_pkg::*;
(
  input  logic                         i_CLK,
  input  logic                         i_RST,
  oled_text_sequencer_if.master        bus,
  output logic                         o_BUSY,
  output logic                         o_ERR,
  output seq_state_t                   o_STATE
);

  localparam int TO_W = $clog2(BUSY_TIMEOUT) + 1;

  seq_state_t state, state_next;

  logic              a_grant, b_grant;
  logic              wr_en, wr_in_range;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;

  logic [7:0]             working [NUM_CHARS];
  logic [NUM_CHARS*8-1:0] ascii_q;
  logic                   dirty;
  logic                   err_q;
  logic [TO_W-1:0]        to_cnt;
  logic                   to_expired;
  logic                   start, snap, timeout, ref_retry, refresh_hit;

  oled_rr_arbiter u_arb (
    .i_CLK   (i_CLK),
    .i_RST   (i_RST),
    .a_valid (bus.i_A_VALID),
    .b_valid (bus.i_B_VALID),
    .a_grant (a_grant),
    .b_grant (b_grant)
  );

  assign bus.o_A_READY = a_grant;
  assign bus.o_B_READY = b_grant;
  assign wr_en         = a_grant || b_grant;
  assign wr_addr       = a_grant ? bus.i_A_ADDR : bus.i_B_ADDR;
  assign wr_data       = a_grant ? bus.i_A_DATA : bus.i_B_DATA;
  assign wr_in_range   = wr_addr < ADDR_W'(NUM_CHARS);

  // State register.
  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      state <= ST_INIT_START;
    end else begin
      state <= state_next;
    end
  end

  // Next state plus start/snapshot/timeout strobes.
  always_comb begin
    state_next = state;
    start      = 1'b0;
    snap       = 1'b0;
    timeout    = 1'b0;
    unique case (state)
      ST_INIT_START: if (bus.i_READY) begin
        start      = 1'b1;
        state_next = ST_INIT_BUSY;
      end
      ST_INIT_BUSY: begin
        if (!bus.i_READY) begin
          state_next = ST_INIT_DONE;
        end else if (to_expired) begin
          timeout    = 1'b1;
          state_next = ST_INIT_START;
        end
      end
      ST_INIT_DONE: if (bus.i_READY) state_next = ST_IDLE;
      ST_IDLE:      if (dirty && bus.i_READY) state_next = ST_SNAP;
      ST_SNAP: begin
        snap       = 1'b1;
        state_next = ST_REF_START;
      end
      ST_REF_START: begin
        start      = 1'b1;
        state_next = ST_REF_BUSY;
      end
      ST_REF_BUSY: begin
        if (!bus.i_READY) begin
          state_next = ST_REF_DONE;
        end else if (to_expired) begin
          timeout    = 1'b1;
          state_next = ST_IDLE;
        end
      end
      ST_REF_DONE: if (bus.i_READY) state_next = ST_IDLE;
      default:     state_next = ST_INIT_START;
    endcase
  end

  assign ref_retry = timeout && (state == ST_REF_BUSY);

  // Busy watchdog: counts cycles spent waiting for i_READY to fall after a start.
  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      to_cnt <= '0;
    end else if (state == ST_INIT_BUSY || state == ST_REF_BUSY) begin
      to_cnt <= to_cnt + 1'b1;
    end else begin
      to_cnt <= '0;
    end
  end

  assign to_expired = (to_cnt == TO_W'(BUSY_TIMEOUT - 1));

`ifdef OLED_SEQ_PERIODIC_REFRESH_EN
  logic [31:0] refresh_cnt;

  // Idle-only refresh timer; restarts whenever the sequencer leaves IDLE.
  always_ff @(posedge i_CLK) begin
    if (i_RST || state != ST_IDLE || refresh_hit) begin
      refresh_cnt <= '0;
    end else begin
      refresh_cnt <= refresh_cnt + 1'b1;
    end
  end

  assign refresh_hit = (state == ST_IDLE) && (refresh_cnt == 32'(REFRESH_PERIOD - 1));
`else
  assign refresh_hit = 1'b0;
`endif

  // Working buffer: takes every accepted in-range write, in any state.
  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      for (int k = 0; k < NUM_CHARS; k++) working[k] <= ASCII_SPACE;
    end else if (wr_en && wr_in_range) begin
      working[wr_addr] <= wr_data;
    end
  end

  // Display buffer: copied from the pre-write working buffer only in SNAP.
  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      ascii_q <= {NUM_CHARS{ASCII_SPACE}};
    end else if (snap) begin
      for (int k = 0; k < NUM_CHARS; k++) ascii_q[cell_lsb(k) +: 8] <= working[k];
    end
  end

  // Dirty flag: a write in the SNAP cycle wins, so that data gets its own render.
  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      dirty <= 1'b1;
    end else if ((wr_en && wr_in_range) || ref_retry || refresh_hit) begin
      dirty <= 1'b1;
    end else if (snap) begin
      dirty <= 1'b0;
    end
  end

  // Sticky error: bad address or OLED_interface never went busy.
  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      err_q <= 1'b0;
    end else if ((wr_en && !wr_in_range) || timeout) begin
      err_q <= 1'b1;
    end
  end

  // Text mode covers the cycle before the start pulse (SNAP) through REF_DONE.
  always_comb begin
    bus.o_MODE = MODE_ON;
    if (state == ST_SNAP || state == ST_REF_START || state == ST_REF_BUSY || state == ST_REF_DONE) begin
      bus.o_MODE = MODE_TEXT;
    end
  end

  // Start is gated by reset so a reset landing on a start cycle never lets it through.
  assign bus.o_START = start && !i_RST;
  assign bus.o_ASCII = ascii_q;
  assign o_BUSY      = (state != ST_IDLE);
  assign o_ERR       = err_q;
  assign o_STATE     = state;

endmodule

// File: tb/tb_oled_text_sequencer.sv
// Self-checking bench for oled_text_sequencer with an OLED_interface responder and a
// behavioural buffer/arbitration model.
module tb_oled_text_sequencer;
  import oled_pkg::*;

  localparam int DW = NUM_CHARS * 8;

  // ---------------- clock / reset ----------------
  logic       i_CLK = 1'b0;
  logic       i_RST = 1'b1;
  logic       o_BUSY, o_ERR;
  seq_state_t o_STATE;
  int         cyc = 0;

  always #5 i_CLK = ~i_CLK;
  always @(posedge i_CLK) cyc <= cyc + 1;

  oled_text_sequencer_if bus ();

  oled_text_sequencer dut (
    .i_CLK   (i_CLK),
    .i_RST   (i_RST),
    .bus     (bus),
    .o_BUSY  (o_BUSY),
    .o_ERR   (o_ERR),
    .o_STATE (o_STATE)
  );

  // ---------------- OLED_interface responder and start monitor ----------------
  logic       oled_ready = 1'b1;
  bit         resp_stuck = 1'b0;
  int         resp_cnt   = 0;
  int         start_cnt  = 0;
  int         start_cyc  = 0;
  logic [1:0] start_mode = 2'b11;
  logic       start_busy = 1'b0;

  assign bus.i_READY = oled_ready;

  always @(negedge i_CLK) begin
    if (i_RST) begin
      resp_cnt   = 0;
      oled_ready = 1'b1;
    end else if (bus.o_START) begin
      start_cnt++;
      start_cyc  = cyc;
      start_mode = bus.o_MODE;
      start_busy = o_BUSY;
      if (!resp_stuck) resp_cnt = 1;
    end else if (resp_cnt > 0) begin
      resp_cnt++;
      if (resp_cnt == 6) oled_ready = 1'b0;
      if (resp_cnt == 26) begin
        oled_ready = 1'b1;
        resp_cnt   = 0;
      end
    end
  end

  // ---------------- scoreboard / reference model ----------------
  int       n_checks = 0;
  int       n_errors = 0;
  logic [7:0] work_m [NUM_CHARS];
  bit       ptr_m = 1'b0;  // 0: A preferred on contention
  bit       err_m = 1'b0;
  logic [DW-1:0] exp_q[$];

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] pack_model();
    logic [DW-1:0] v;
    for (int k = 0; k < NUM_CHARS; k++) v[(NUM_CHARS-1-k)*8 +: 8] = work_m[k];
    return v;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NUM_CHARS; k++) work_m[k] = ASCII_SPACE;
    ptr_m = 1'b0;
    err_m = 1'b0;
  endtask

  task automatic model_write(input logic [ADDR_W-1:0] addr, input logic [7:0] data);
    if (int'(addr) < NUM_CHARS) work_m[addr] = data;
    else err_m = 1'b1;
  endtask

  // The display, once the sequencer has settled, must hold the latest write to every cell.
  task automatic check_display(input string tag);
    exp_q.push_back(pack_model());
    check(tag, bus.o_ASCII, exp_q.pop_front());
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge i_CLK);
    #1;
  endtask

  task automatic drive(input bit av, input logic [ADDR_W-1:0] aa, input logic [7:0] ad,
                       input bit bv, input logic [ADDR_W-1:0] ba, input logic [7:0] bd);
    bit ga, gb;
    bus.i_A_VALID = av;
    bus.i_A_ADDR  = aa;
    bus.i_A_DATA  = ad;
    bus.i_B_VALID = bv;
    bus.i_B_ADDR  = ba;
    bus.i_B_DATA  = bd;
    ga = av && (!bv || !ptr_m);
    gb = bv && (!av || ptr_m);
    @(negedge i_CLK);
    check("a_ready", DW'(bus.o_A_READY), DW'(ga));
    check("b_ready", DW'(bus.o_B_READY), DW'(gb));
    if (ga) begin
      model_write(aa, ad);
      ptr_m = 1'b1;
    end else if (gb) begin
      model_write(ba, bd);
      ptr_m = 1'b0;
    end
    tick();
    bus.i_A_VALID = 1'b0;
    bus.i_B_VALID = 1'b0;
  endtask

  task automatic wait_start(input string tag, input int prev);
    bit ok = 1'b0;
    for (int i = 0; i < 400 && !ok; i++) begin
      if (start_cnt > prev) ok = 1'b1;
      else tick();
    end
    check(tag, DW'(ok), DW'(1'b1));
  endtask

  task automatic wait_quiet(input string tag);
    int run = 0;
    bit ok  = 1'b0;
    for (int i = 0; i < 3000 && !ok; i++) begin
      tick();
      if (!o_BUSY) run++;
      else run = 0;
      if (run >= 5) ok = 1'b1;
    end
    check(tag, DW'(ok), DW'(1'b1));
  endtask

  task automatic boot(input string tag);
    int prev = start_cnt;
    wait_start({tag, "_init_start"}, prev);
    check({tag, "_init_mode"}, DW'(start_mode), DW'(MODE_ON));
    wait_start({tag, "_boot_render"}, prev + 1);
    check({tag, "_boot_mode"}, DW'(start_mode), DW'(MODE_TEXT));
    wait_quiet({tag, "_boot_quiet"});
    check_display({tag, "_boot_ascii"});
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #900_000;
    $display("FAIL watchdog: simulation time limit reached, got=running exp=finished");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    int prev, w_cyc, t_err;
    bit in_win;
    logic [DW-1:0] snap_ascii;

    bus.i_A_VALID = 1'b0; bus.i_A_ADDR = '0; bus.i_A_DATA = '0;
    bus.i_B_VALID = 1'b0; bus.i_B_ADDR = '0; bus.i_B_DATA = '0;
    model_reset();

    // Reset values while i_READY is high.
    repeat (3) tick();
    @(negedge i_CLK);
    check("rst_start", DW'(bus.o_START), DW'(1'b0));
    check("rst_mode",  DW'(bus.o_MODE),  DW'(MODE_ON));
    check("rst_busy",  DW'(o_BUSY),      DW'(1'b1));
    check("rst_err",   DW'(o_ERR),       DW'(1'b0));
    check_display("rst_ascii");
    tick();
    i_RST = 1'b0;

    boot("p1");
    check("p1_err", DW'(o_ERR), DW'(err_m));

    // Single write from IDLE: start pulse three cycles later, busy through the render.
    prev  = start_cnt;
    w_cyc = cyc;
    drive(1'b1, 7'd0, 8'h45, 1'b0, 7'd0, 8'h00);
    wait_start("e_start", prev);
    check("e_latency", DW'(start_cyc - w_cyc), DW'(3));
    check("e_mode",    DW'(start_mode),        DW'(MODE_TEXT));
    check("e_busy",    DW'(start_busy),        DW'(1'b1));
    wait_quiet("e_quiet");
    check("e_cell0", DW'(bus.o_ASCII[DW-1 -: 8]), DW'(8'h45));
    check_display("e_ascii");

    // Hand priority back to A, then contend on a pair of cells for four cycles.
    drive(1'b0, 7'd0, 8'h00, 1'b1, 7'd1, 8'h42);
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 7'(5 + (i % 2)), 8'($urandom_range(33, 126)),
            1'b1, 7'(5 + ((i / 2) % 2)), 8'($urandom_range(33, 126)));
    end
    wait_quiet("rr_quiet");
    check_display("rr_ascii");

    // Random traffic overlapping renders.
    for (int i = 0; i < 80; i++) begin
      drive(1'($urandom_range(0, 1)), 7'($urandom_range(0, NUM_CHARS - 1)), 8'($urandom_range(32, 126)),
            1'($urandom_range(0, 1)), 7'($urandom_range(0, NUM_CHARS - 1)), 8'($urandom_range(32, 126)));
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 30)) tick();
    end
    wait_quiet("rand_quiet");
    check_display("rand_ascii");
    check("rand_err", DW'(o_ERR), DW'(err_m));

    // No writes: no further renders.
    prev = start_cnt;
    repeat (300) tick();
    check("idle_no_start", DW'(start_cnt), DW'(prev));

    // Out-of-range address: accepted, flagged, nothing rendered.
    prev       = start_cnt;
    snap_ascii = bus.o_ASCII;
    drive(1'b0, 7'd0, 8'h00, 1'b1, 7'd96, 8'h58);
    check("oor_err", DW'(o_ERR), DW'(err_m));
    repeat (50) tick();
    check("oor_no_start", DW'(start_cnt), DW'(prev));
    check("oor_ascii", bus.o_ASCII, snap_ascii);
    check_display("oor_model");

    // Reset landing on the render start cycle.
    drive(1'b1, 7'd10, 8'h4b, 1'b0, 7'd0, 8'h00);
    tick();
    tick();
    i_RST = 1'b1;
    @(negedge i_CLK);
    check("mid_rst_start", DW'(bus.o_START), DW'(1'b0));
    tick();
    model_reset();
    check("mid_rst_busy", DW'(o_BUSY),     DW'(1'b1));
    check("mid_rst_err",  DW'(o_ERR),      DW'(err_m));
    check("mid_rst_mode", DW'(bus.o_MODE), DW'(MODE_ON));
    check_display("mid_rst_ascii");
    i_RST = 1'b0;
    boot("p2");

    // OLED_interface never goes busy: timeout, error, then a render retry.
    resp_stuck = 1'b1;
    prev = start_cnt;
    drive(1'b1, 7'd95, 8'h5a, 1'b0, 7'd0, 8'h00);
    wait_start("to_start", prev);
    check("to_mode", DW'(start_mode), DW'(MODE_TEXT));
    t_err = -1;
    for (int i = 0; i < 200 && t_err < 0; i++) begin
      if (o_ERR) t_err = cyc;
      else tick();
    end
    resp_stuck = 1'b0;
    err_m      = 1'b1;
    in_win     = (t_err - start_cyc >= BUSY_TIMEOUT) && (t_err - start_cyc <= BUSY_TIMEOUT + 2);
    check("to_window", DW'(in_win), DW'(1'b1));
    check("to_err",    DW'(o_ERR),  DW'(err_m));
    wait_start("to_retry", start_cnt);
    check("to_retry_mode", DW'(start_mode), DW'(MODE_TEXT));
    wait_quiet("to_quiet");
    check_display("to_ascii");
    check("to_err_sticky", DW'(o_ERR), DW'(err_m));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
